alu_bit_serial_seq: RTL and testbench
=====================================

Name: alu_bit_serial_seq

Overview:
- Bit-serial MIPS ALU sequencer. Drives a 1-bit ALU slice LSB-first over WIDTH cycles.
- Keeps the carry chain in a register and assembles the WIDTH-bit result.
- Uses the same 3-bit ctrl encoding as the combinational ALU.
- Area-reduced alternative for the multicycle datapath. The control FSM issues start/ctrl and waits for done.

Parameters:
- WIDTH, 32, operand/result width in bits (>=2).
- CNT_W, $clog2(WIDTH), width of the bit-index counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  request pulse; sampled only in IDLE
- ctrl  input  3  000 AND, 001 OR, 100 XOR, 101 NOR, 010 ADD, 110 SUB, 111 SLT; others are invalid
- a  input  WIDTH  operand A; latched on an accepted start
- b  input  WIDTH  operand B; latched on an accepted start
- busy  output  1  high from the cycle after an accepted start through the DONE cycle
- done  output  1  one-cycle pulse when result is valid
- result  output  WIDTH  final result; held until the next done
- zero  output  1  (result == 0); registered with result
- overflow  output  1  signed overflow for ADD/SUB; 0 for all other ops

Behaviour:
- Reset: synchronous, active-high, on clk. Forces state=IDLE, busy=0, done=0, result=0, zero=0 (reset value, not recomputed), overflow=0, counter=0, carry=0. Applies mid-operation: the operation is abandoned and produces no done.
- States: IDLE, RUN, SLT_FIX, DONE.
- IDLE:
  - start=1 at edge T latches a, b, ctrl.
  - Sets carry=1 for SUB/SLT (B is inverted per bit), else carry=0.
  - Sets counter=0, then goes to RUN.
  - start is ignored in every other state; there is no queueing.
- RUN, cycle T+1+i processes bit i (i = 0..WIDTH-1):
  - Slice inputs are a[i], b[i]^inv, carry.
  - The slice bit result is shifted into the result shift register MSB-first, so the register is correctly aligned after WIDTH shifts.
  - carry <= slice carry-out.
  - At i=WIDTH-1 the carry-in/carry-out of the MSB are captured: ovf = cin_msb ^ cout_msb, set = sum_msb ^ ovf.
  - Leaving RUN: next state is SLT_FIX if ctrl=111, else DONE.
- SLT_FIX (one cycle): result <= {WIDTH-1 zeros, set}.
- DONE (one cycle):
  - done=1, busy=1.
  - result, zero and overflow are updated on entry, before the done cycle, and are stable during it.
  - Next state is IDLE.
  - A start in the DONE cycle is ignored.
- Latency from the start edge T:
  - done is high in cycle T+WIDTH+1 for all ops except SLT.
  - done is high in cycle T+WIDTH+2 for SLT.
- overflow: ovf for ctrl 010/110; 0 for all other ctrl values, including 111.
- Invalid ctrl (011): the op runs with normal latency and the slice returns 0, giving result=0, zero=1, overflow=0.
- Outputs are held between operations. result, zero and overflow change only on entry to DONE or on rst.
- Counter width: when WIDTH is not a power of two, compare against WIDTH-1 rather than relying on wrap.

Decomposition:
- Package alu_pkg holds:
  - typedef enum logic [2:0] alu_ctrl_t (ALU_AND=000, ALU_OR=001, ALU_ADD=010, ALU_SUB=110, ALU_SLT=111, ALU_XOR=100, ALU_NOR=101).
  - typedef enum seq_state_t {IDLE, RUN, SLT_FIX, DONE}.
  - function is_arith(ctrl), true for 010/110/111.
- One sub-module, alu_serial_slice:
  - Purely combinational.
  - Inputs a, b, cin, ctrl; outputs res, cout.
  - Contains the full adder and the logic mux.
- Top module contains the FSM, counter, carry register, and operand/result registers.

Test Plan:
- ADD a=0x7FFFFFFF, b=0x00000001, start at T -> done only at T+33; result=0x80000000, overflow=1, zero=0; busy high T+1..T+33.
- SUB a=5, b=5 -> result=0, zero=1, overflow=0; then SUB a=0x80000000, b=1 -> result=0x7FFFFFFF, overflow=1.
- SLT a=0xFFFFFFFF, b=1 -> done at T+34, result=1, overflow=0; SLT a=1, b=0xFFFFFFFF -> result=0; SLT a=0x80000000, b=1 (overflowing subtract) -> result=1.
- Logic ops with a=0xF0F0F0F0, b=0xFF00FF00:
  - AND -> 0xF000F000; OR -> 0xFFF0FFF0; XOR -> 0x0FF00FF0; NOR -> 0x000F000F.
  - Each with overflow=0; ctrl=011 -> result=0, zero=1.
- start re-asserted with new operands every cycle during RUN and in the DONE cycle -> ignored; first result unchanged; exactly one done pulse.
- rst asserted at T+10 of an ADD -> next cycle busy=0, done=0, result=0; no done follows; a fresh start afterwards completes normally in 33 cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU control encoding, sequencer states and op helpers
package alu_pkg;
  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111,
    ALU_XOR = 3'b100,
    ALU_NOR = 3'b101
  } alu_ctrl_t;
  typedef enum logic [1:0] {IDLE, RUN, SLT_FIX, DONE} seq_state_t;
  function automatic logic is_arith(input logic [2:0] c);
    return c == ALU_ADD || c == ALU_SUB || c == ALU_SLT;
  endfunction
endpackage

// File: rtl/alu_serial_slice.sv
// alu_serial_slice: one-bit ALU slice, full adder plus logic-op mux
module alu_serial_slice
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [2:0] ctrl,
  output logic       res,
  output logic       cout
);
  logic sum;
  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (cin & (a ^ b));
    res  = is_arith(ctrl)   ? sum :
           ctrl == ALU_AND  ? a & b :
           ctrl == ALU_OR   ? a | b :
           ctrl == ALU_XOR  ? a ^ b :
           ctrl == ALU_NOR  ? ~(a | b) : 1'b0;
  end
endmodule

// File: rtl/alu_bit_serial_seq.sv
// alu_bit_serial_seq: LSB-first bit-serial ALU sequencer around a one-bit slice
module alu_bit_serial_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);
  seq_state_t       state;
  logic [WIDTH-1:0] a_sr, b_sr, sr, sr_next;
  logic [2:0]       op;
  logic [CNT_W-1:0] cnt;
  logic             carry, set_q, inv, s_res, s_cout, last, ovf, set;
  alu_serial_slice u_slice (
    .a   (a_sr[0]),
    .b   (b_sr[0] ^ inv),
    .cin (carry),
    .ctrl(op),
    .res (s_res),
    .cout(s_cout)
  );
  always_comb begin
    inv     = op == ALU_SUB || op == ALU_SLT;
    last    = cnt == CNT_W'(WIDTH - 1);
    ovf     = carry ^ s_cout;
    set     = s_res ^ ovf;
    sr_next = {s_res, sr[WIDTH-1:1]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      cnt      <= '0;
      carry    <= 1'b0;
      set_q    <= 1'b0;
      op       <= 3'b000;
      a_sr     <= '0;
      b_sr     <= '0;
      sr       <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            op    <= ctrl;
            carry <= ctrl == ALU_SUB || ctrl == ALU_SLT;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          sr    <= sr_next;
          carry <= s_cout;
          cnt   <= cnt + 1'b1;
          if (last) begin
            if (op == ALU_SLT) begin
              set_q <= set;
              state <= SLT_FIX;
            end else begin
              result   <= sr_next;
              zero     <= sr_next == '0;
              overflow <= (op == ALU_ADD || op == ALU_SUB) && ovf;
              done     <= 1'b1;
              state    <= DONE;
            end
          end
        end
        SLT_FIX: begin
          result   <= {{(WIDTH-1){1'b0}}, set_q};
          zero     <= ~set_q;
          overflow <= 1'b0;
          done     <= 1'b1;
          state    <= DONE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_bit_serial_seq.sv
// tb_alu_bit_serial_seq: randomized and directed check of the serial ALU against an arithmetic model
module tb_alu_bit_serial_seq;
  localparam int W = 32;
  logic         clk = 1'b0;
  logic         rst, start, busy, done, zero, overflow;
  logic [2:0]   ctrl;
  logic [W-1:0] a, b, result;
  int           total = 0;
  int           bad = 0;
  always #5 clk = ~clk;
  alu_bit_serial_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .ctrl(ctrl), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .zero(zero), .overflow(overflow)
  );
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic void model(input logic [2:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output logic v);
    v = 1'b0;
    case (c)
      3'b000: r = x & y;
      3'b001: r = x | y;
      3'b100: r = x ^ y;
      3'b101: r = ~(x | y);
      3'b010: begin r = x + y; v = x[W-1] == y[W-1] && r[W-1] != x[W-1]; end
      3'b110: begin r = x - y; v = x[W-1] != y[W-1] && r[W-1] != x[W-1]; end
      3'b111: r = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
      default: r = '0;
    endcase
  endfunction
  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'hFFFF_FFFF;
      3: return W'($urandom_range(0, 3));
      default: return W'($urandom);
    endcase
  endfunction
  task automatic run_op(input logic [2:0] c, input logic [W-1:0] x, input logic [W-1:0] y, input bit hammer);
    logic [W-1:0] er;
    logic         ev;
    int           lat, n;
    bit           seen;
    model(c, x, y, er, ev);
    lat   = (c == 3'b111) ? W + 1 : W;
    ctrl  = c;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk); #1;
    check("busy_first", busy, 1);
    if (!hammer) start = 1'b0;
    n    = 0;
    seen = 0;
    for (int i = 1; i <= W + 3 && !seen; i++) begin
      if (hammer) begin
        start = 1'b1;
        a     = $urandom;
        b     = $urandom;
        ctrl  = 3'($urandom);
      end
      @(posedge clk); #1;
      if (done) begin
        seen = 1;
        n    = i;
      end else check("busy_run", busy, 1);
    end
    check("done_seen", W'(seen), 1);
    check("latency", W'(n), W'(lat));
    check("busy_done", busy, 1);
    check("result", result, er);
    check("zero", zero, W'(er == '0));
    check("overflow", overflow, W'(ev));
    @(posedge clk); #1;
    start = 1'b0;
    check("done_clear", done, 0);
    check("busy_clear", busy, 0);
    @(posedge clk); #1;
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
    check("result_held", result, er);
  endtask
  initial begin
    bit seen;
    rst   = 1'b1;
    start = 1'b0;
    ctrl  = 3'b000;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 0);
    run_op(3'b110, 32'd5, 32'd5, 0);
    run_op(3'b110, 32'h8000_0000, 32'h0000_0001, 0);
    run_op(3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    run_op(3'b111, 32'h0000_0001, 32'hFFFF_FFFF, 0);
    run_op(3'b111, 32'h8000_0000, 32'h0000_0001, 0);
    foreach (ctrl[i]) ;
    for (int c = 0; c < 8; c++) run_op(3'(c), 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
    run_op(3'b010, 32'h1234_5678, 32'h1111_1111, 1);
    run_op(3'b111, 32'h8000_0000, 32'h0000_0001, 1);
    ctrl  = 3'b010;
    a     = 32'd1;
    b     = 32'd2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_result", result, 0);
    check("midrst_zero", zero, 0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    check("midrst_no_done", W'(seen), 0);
    run_op(3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    repeat (40) run_op(3'($urandom_range(0, 7)), pick(), pick(), $urandom_range(0, 3) == 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
